// File: rtl/data_memory_responder.sv
// Line-granular external data memory answering L1 data-cache line requests.
// Latency: ack_o pulses LATENCY cycles after request capture; one request per LATENCY+3 cycles.
// Backpressure: none; requests arriving outside IDLE are ignored, busy_o signals in-flight work.
module data_memory_responder #(
  parameter int LINE_WIDTH = 256,
  parameter int DEPTH      = 512,
  parameter int LATENCY    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           addr_i,
  input  logic [LINE_WIDTH-1:0] data_i,
  input  logic                  cs_i,
  input  logic                  we_i,
  output logic [LINE_WIDTH-1:0] data_o,
  output logic                  ack_o,
  output logic                  busy_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_ACK  = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;
  logic                    we_q;
  logic [LINE_WIDTH-1:0]   wdat_q;
  logic [LINE_WIDTH-1:0]   data_q;
  logic                    ack_q;
  logic                    busy_q;

  // Storage is deliberately not reset: DRAM contents survive a controller reset.
  logic [LINE_WIDTH-1:0]   mem_q [DEPTH];

  logic [IW-1:0]           idx_d;
  logic                    serve_d;

  // Byte offset and bits above the line index are don't-care, so addresses alias.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{addr_i[31:IW+5], addr_i[4:0]};

  assign idx_d = addr_i[IW+4:5];

  // The counter starts at 1 on capture, so reaching LATENCY means this edge
  // is capture + LATENCY, the edge that enters ACK.
  assign serve_d = (state_q == S_BUSY) && (cnt_q == CW'(LATENCY));

  // Transaction sequencer with registered data, ack and busy outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      wdat_q  <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_i) begin
            idx_q   <= idx_d;
            we_q    <= we_i;
            wdat_q  <= data_i;
            cnt_q   <= CW'(1);
            busy_q  <= 1'b1;
            state_q <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (serve_d) begin
            if (!we_q) begin
              data_q <= mem_q[idx_q];
            end
            ack_q   <= 1'b1;
            state_q <= S_ACK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_ACK: begin
          ack_q   <= 1'b0;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          // cs_i is not sampled here, so an initiator that is slow to drop
          // its request after ack is not serviced a second time.
          cnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Write commit happens only on ACK entry; a reset before then drops the write.
  always_ff @(posedge clk) begin
    if (serve_d && we_q) begin
      mem_q[idx_q] <= wdat_q;
    end
  end

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int LW    = 256;
  localparam int DEP   = 512;
  localparam int LAT   = 10;

  logic          clk;
  logic          rst;
  logic [31:0]   addr_i;
  logic [LW-1:0] data_i;
  logic          cs_i;
  logic          we_i;
  logic [LW-1:0] data_o;
  logic          ack_o;
  logic          busy_o;
  bit            clk_en;

  int total = 0;
  int bad   = 0;

  // Reference: line store keyed by line index, plus last value seen on data_o.
  logic [LW-1:0] mem_m [int];
  logic [LW-1:0] last_rd;

  data_memory_responder #(.LINE_WIDTH(LW), .DEPTH(DEP), .LATENCY(LAT)) dut (
    .clk    (clk),
    .rst    (rst),
    .addr_i (addr_i),
    .data_i (data_i),
    .cs_i   (cs_i),
    .we_i   (we_i),
    .data_o (data_o),
    .ack_o  (ack_o),
    .busy_o (busy_o)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % DEP);
  endfunction

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Builds an address for a line with random ignored bits above and below the index.
  function automatic logic [31:0] alias_addr(input int line);
    logic [31:0] a;
    a = $urandom;
    a[13:5] = line[8:0];
    return a;
  endfunction

  // One full transaction from capture to return to IDLE, checking timing and data.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [LW-1:0] wdat,
                         input bit scramble, input string tag);
    int n;
    int ln;
    ln = line_of(addr);
    @(negedge clk);
    cs_i = 1'b1; we_i = we; addr_i = addr; data_i = wdat;
    @(posedge clk); #1;
    chk({tag, "_busy_rise"}, LW'(busy_o), LW'(1));
    @(negedge clk);
    cs_i = 1'b0;
    if (scramble) begin
      addr_i = alias_addr((ln + 2) % DEP);
      we_i   = ~we;
      data_i = rnd_line();
    end
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ack_o && n < 4 * LAT);
    chk({tag, "_latency"}, LW'(n), LW'(LAT));
    if (we) begin
      mem_m[ln] = wdat;
    end else begin
      last_rd = mem_m[ln];
    end
    chk({tag, "_data"}, data_o, last_rd);
    @(posedge clk); #1;
    chk({tag, "_ack_fall"}, LW'(ack_o), LW'(0));
    chk({tag, "_busy_hold"}, LW'(busy_o), LW'(1));
    @(posedge clk); #1;
    chk({tag, "_busy_fall"}, LW'(busy_o), LW'(0));
  endtask

  initial begin
    int acks [$];
    int n;
    logic [LW-1:0] old2;

    clk_en = 1'b0;
    rst = 1'b1; cs_i = 1'b0; we_i = 1'b0; addr_i = '0; data_i = '0;
    last_rd = '0;

    // Reset with the clock stopped: outputs must clear without an edge.
    #3 rst = 1'b0;
    #1;
    chk("rst_ack", LW'(ack_o), LW'(0));
    chk("rst_busy", LW'(busy_o), LW'(0));
    chk("rst_data", data_o, '0);
    clk_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Preload line 3 through the interface, then read it at byte address 0x60.
    run_req(1'b1, 32'h0000_0060, {8{32'hDEADBEEF}}, 1'b0, "pre3");
    run_req(1'b0, 32'h0000_0060, '0, 1'b0, "rd3");
    chk("rd3_value", data_o, {8{32'hDEADBEEF}});

    // Write line 5, read it back through an aliasing address.
    run_req(1'b1, 32'h0000_00A4, {8{32'h12345678}}, 1'b0, "wr5");
    run_req(1'b0, 32'h8000_40BF, '0, 1'b0, "rd5");
    chk("rd5_alias", data_o, {8{32'h12345678}});

    // Inputs changed during BUSY must not affect the request in flight.
    run_req(1'b1, alias_addr(7), rnd_line(), 1'b0, "wr7");
    run_req(1'b1, alias_addr(9), rnd_line(), 1'b0, "wr9");
    run_req(1'b0, alias_addr(7), '0, 1'b1, "rd7s");
    run_req(1'b0, alias_addr(9), '0, 1'b0, "rd9");

    // Reset in the middle of a write: old contents survive.
    run_req(1'b1, alias_addr(2), rnd_line(), 1'b0, "wr2");
    old2 = mem_m[2];
    @(negedge clk);
    cs_i = 1'b1; we_i = 1'b1; addr_i = alias_addr(2); data_i = {16{16'hCAFE}};
    @(posedge clk);
    @(negedge clk) cs_i = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    last_rd = '0;
    chk("mrst_ack", LW'(ack_o), LW'(0));
    chk("mrst_busy", LW'(busy_o), LW'(0));
    chk("mrst_data", data_o, '0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    run_req(1'b0, alias_addr(2), '0, 1'b0, "rd2");
    chk("rd2_old", data_o, old2);

    // Random mix over a small set of lines with random aliasing bits.
    for (int i = 0; i < 24; i++) begin
      int ln;
      bit w;
      ln = int'($urandom_range(0, 15));
      w  = ($urandom_range(0, 1) == 1) || !mem_m.exists(ln);
      run_req(w, alias_addr(ln), rnd_line(), bit'($urandom_range(0, 1)), w ? "rnd_wr" : "rnd_rd");
    end

    // cs_i held high continuously: one service per LAT+3 cycles, no double service.
    @(negedge clk);
    cs_i = 1'b1; we_i = 1'b0; addr_i = alias_addr(3);
    for (int c = 0; c < 46; c++) begin
      @(posedge clk); #1;
      if (ack_o) begin
        acks.push_back(c);
        chk("b2b_data", data_o, mem_m[3]);
      end
    end
    @(negedge clk) cs_i = 1'b0;
    chk("b2b_count", LW'(acks.size()), LW'(3));
    if (acks.size() == 3) begin
      chk("b2b_first", LW'(acks[0]), LW'(LAT));
      chk("b2b_gap1", LW'(acks[1] - acks[0]), LW'(LAT + 3));
      chk("b2b_gap2", LW'(acks[2] - acks[1]), LW'(LAT + 3));
    end
    n = 0;
    while (busy_o && n < 4 * LAT) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b_drain", LW'(busy_o), LW'(0));
    last_rd = mem_m[3];
    run_req(1'b0, alias_addr(5), '0, 1'b0, "rd5b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
